// File: rtl/vram_blit.sv
// rtl/vram_blit.sv - VRAM fill / scroll-up blitter; optional i_abort when VRAM_BLIT_ABORT_EN is defined.
module vram_blit #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int COLS   = 64,
  parameter int ROWS   = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_mode,
  input  logic [ADDR_W-1:0]          i_first,
  input  logic [ADDR_W-1:0]          i_last,
  input  logic [$clog2(ROWS+1)-1:0]  i_nrows,
  input  logic [DATA_W-1:0]          i_fill,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [ADDR_W-1:0]          o_vram_addr,
  output logic                       o_vram_ce,
  output logic                       o_vram_w,
  output logic [DATA_W-1:0]          o_vram_din,
  input  logic [DATA_W-1:0]          i_vram_dout
`ifdef VRAM_BLIT_ABORT_EN
  ,
  input  logic                       i_abort
`endif
);

  localparam int AW1  = ADDR_W + 1;
  localparam int NR_W = $clog2(ROWS + 1);
  localparam logic [AW1-1:0] SCREEN_END = AW1'(ROWS * COLS - 1);
  localparam logic [AW1-1:0] COLS_X     = AW1'(COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SCR_RD,
    S_SCR_WR,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [AW1-1:0]      cur_q, cur_d;
  logic [AW1-1:0]      end_q, end_d;
  logic [AW1-1:0]      copy_end_q, copy_end_d;
  logic [ADDR_W-1:0]   src_off_q, src_off_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      end_q      <= '0;
      copy_end_q <= '0;
      src_off_q  <= '0;
      fill_q     <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      end_q      <= end_d;
      copy_end_q <= copy_end_d;
      src_off_q  <= src_off_d;
      fill_q     <= fill_d;
      addr_q     <= addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    end_d       = end_q;
    copy_end_d  = copy_end_q;
    src_off_d   = src_off_q;
    fill_d      = fill_q;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_vram_addr = addr_q;
    o_vram_ce   = 1'b0;
    o_vram_w    = 1'b0;
    o_vram_din  = '0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          fill_d = i_fill;
          if (!i_mode) begin
            if (i_first > i_last) begin
              state_d = S_DONE;
            end else begin
              cur_d   = {1'b0, i_first};
              end_d   = {1'b0, i_last};
              state_d = S_FILL;
            end
          end else if (i_nrows == '0) begin
            state_d = S_DONE;
          end else if (i_nrows >= NR_W'(ROWS)) begin
            cur_d   = '0;
            end_d   = SCREEN_END;
            state_d = S_FILL;
          end else begin
            // copy_end is the last destination word of the copy phase
            cur_d      = '0;
            src_off_d  = ADDR_W'(i_nrows) * ADDR_W'(COLS);
            copy_end_d = (AW1'(ROWS) - AW1'(i_nrows)) * COLS_X - AW1'(1);
            state_d    = S_SCR_RD;
          end
        end
      end
      S_FILL: begin
        o_busy      = 1'b1;
        o_vram_addr = cur_q[ADDR_W-1:0];
        o_vram_ce   = 1'b1;
        o_vram_w    = 1'b1;
        o_vram_din  = fill_q;
        if (cur_q == end_q) state_d = S_DONE;
        else                cur_d   = cur_q + AW1'(1);
      end
      S_SCR_RD: begin
        o_busy      = 1'b1;
        o_vram_addr = cur_q[ADDR_W-1:0] + src_off_q;
        o_vram_ce   = 1'b1;
        state_d     = S_SCR_WR;
      end
      S_SCR_WR: begin
        o_busy      = 1'b1;
        o_vram_addr = cur_q[ADDR_W-1:0];
        o_vram_ce   = 1'b1;
        o_vram_w    = 1'b1;
        o_vram_din  = i_vram_dout;
        if (cur_q == copy_end_q) begin
          cur_d   = copy_end_q + AW1'(1);
          end_d   = SCREEN_END;
          state_d = S_FILL;
        end else begin
          cur_d   = cur_q + AW1'(1);
          state_d = S_SCR_RD;
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef VRAM_BLIT_ABORT_EN
    if (o_busy && i_abort) state_d = S_DONE;
`endif

    addr_d = o_busy ? o_vram_addr : addr_q;
  end

endmodule

// File: tb/tb_vram_blit.sv
// tb/tb_vram_blit.sv - randomized directed bench for vram_blit against a row/column reference model.
module tb_vram_blit;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int COLS  = 64;
  localparam int ROWS  = 32;
  localparam int NRW   = 6;
  localparam int DEPTH = 2048;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           mode = 1'b0;
  logic [AW-1:0]  first = '0;
  logic [AW-1:0]  last = '0;
  logic [NRW-1:0] nrows = '0;
  logic [DW-1:0]  fill = '0;
  logic           busy, done, ce, w;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  din;
  logic [DW-1:0]  vram_dout = '0;
`ifdef VRAM_BLIT_ABORT_EN
  logic           abort = 1'b0;
`endif

  vram_blit #(.ADDR_W(AW), .DATA_W(DW), .COLS(COLS), .ROWS(ROWS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
    .i_first(first), .i_last(last), .i_nrows(nrows), .i_fill(fill),
    .o_busy(busy), .o_done(done), .o_vram_addr(addr), .o_vram_ce(ce),
    .o_vram_w(w), .o_vram_din(din), .i_vram_dout(vram_dout)
`ifdef VRAM_BLIT_ABORT_EN
    , .i_abort(abort)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] snap [DEPTH];
  logic [DW-1:0] expm [DEPTH];
  logic          pl_en = 1'b0;
  logic          pl_rows = 1'b0;
  logic          cnt_clr = 1'b0;
  int            wr_cnt = 0, rd_cnt = 0, idle_acc = 0;
  logic [AW-1:0] last_wr = '0;

  // VRAM model: synchronous write, read data valid the cycle after the read
  always @(posedge clk) begin
    if (pl_en) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= pl_rows ? DW'(a / COLS) : DW'($urandom);
    end else if (rst_n && ce) begin
      if (w) mem[addr] <= din;
      else   vram_dout <= mem[addr];
    end
  end

  always @(posedge clk) begin
    if (cnt_clr) begin
      wr_cnt <= 0; rd_cnt <= 0; idle_acc <= 0;
    end else if (rst_n && ce) begin
      if (w) begin wr_cnt <= wr_cnt + 1; last_wr <= addr; end
      else rd_cnt <= rd_cnt + 1;
      if (!busy) idle_acc <= idle_acc + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int exp_addr = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic rows);
    @(negedge clk); pl_en = 1'b1; pl_rows = rows;
    @(negedge clk); pl_en = 1'b0;
  endtask

  task automatic take_snap();
    for (int a = 0; a < DEPTH; a++) snap[a] = mem[a];
  endtask

  // Reference: what the screen should look like afterwards, from rows/columns
  task automatic model(input logic m, input int f, input int l, input int n, input logic [DW-1:0] fv,
                       output int e_wr, output int e_rd, output int e_done);
    int nn;
    for (int a = 0; a < DEPTH; a++) expm[a] = snap[a];
    e_wr = 0; e_rd = 0; e_done = 1;
    if (!m) begin
      if (f <= l) begin
        for (int a = f; a <= l; a++) expm[a] = fv;
        e_wr = l - f + 1;
        e_done = e_wr + 1;
      end
    end else if (n > 0) begin
      nn = (n >= ROWS) ? ROWS : n;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          expm[r*COLS + c] = (r + nn < ROWS) ? snap[(r + nn)*COLS + c] : fv;
      e_rd = (ROWS - nn) * COLS;
      e_wr = ROWS * COLS;
      e_done = 2 * e_rd + nn * COLS + 1;
    end
  endtask

  task automatic run_op(input logic m, input int f, input int l, input int n, input logic [DW-1:0] fv,
                        input int poke_cyc, input int abort_cyc, input int rst_cyc,
                        output int done_cyc, output int busy_cyc);
    @(negedge clk);
    mode = m; first = AW'(f); last = AW'(l); nrows = NRW'(n); fill = fv;
    start = 1'b1; cnt_clr = 1'b1;
    @(negedge clk);
    start = 1'b0; cnt_clr = 1'b0;
    done_cyc = -1; busy_cyc = 0;
    for (int cyc = 1; cyc <= 12000; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin done_cyc = cyc; break; end
      if (cyc == rst_cyc) begin rst_n = 1'b0; done_cyc = -2; break; end
      mode = 1'($urandom); first = AW'($urandom); last = AW'($urandom);
      nrows = NRW'($urandom); fill = DW'($urandom);
      start = (cyc == poke_cyc);
`ifdef VRAM_BLIT_ABORT_EN
      abort = (cyc == abort_cyc);
`else
      if (abort_cyc < 0 && cyc == 0) start = 1'b0;
`endif
    end
    start = 1'b0;
`ifdef VRAM_BLIT_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  task automatic mem_check(input string tag);
    int bad = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== expm[a]) bad++;
    check({tag, ".mem_bad_words"}, bad, 0);
  endtask

  task automatic do_op(input string tag, input logic m, input int f, input int l, input int n,
                       input logic [DW-1:0] fv, input int poke_cyc);
    int e_wr, e_rd, e_done, d_cyc, b_cyc;
    take_snap();
    model(m, f, l, n, fv, e_wr, e_rd, e_done);
    run_op(m, f, l, n, fv, poke_cyc, -1, -1, d_cyc, b_cyc);
    check({tag, ".done_cycle"}, d_cyc, e_done);
    check({tag, ".busy_cycles"}, b_cyc, e_done - 1);
    check({tag, ".writes"}, wr_cnt, e_wr);
    check({tag, ".reads"}, rd_cnt, e_rd);
    check({tag, ".idle_access"}, idle_acc, 0);
    if (e_wr > 0) exp_addr = m ? DEPTH - 1 : l;
    @(negedge clk);
    check({tag, ".done_pulse_end"}, {done, busy}, 2'b00);
    check({tag, ".idle_ce_w_din"}, {ce, w, din}, '0);
    check({tag, ".addr_hold"}, addr, exp_addr);
    if (e_wr > 0) check({tag, ".last_write"}, last_wr, exp_addr);
    mem_check(tag);
  endtask

  initial begin
    int f, l, n, d_cyc, b_cyc, e_wr, e_rd, e_done;
    repeat (3) @(negedge clk);
    check("reset.outputs", {busy, done, ce, w, addr, din}, '0);
    preload(1'b0);
    @(negedge clk); rst_n = 1'b1;

    do_op("fill_full", 1'b0, 0, DEPTH - 1, 0, 8'h20, 50);
    do_op("fill_empty", 1'b0, 10, 9, 0, 8'h41, -1);
    do_op("fill_top", 1'b0, DEPTH - 1, DEPTH - 1, 0, 8'h5a, -1);
    for (int k = 0; k < 3; k++) begin
      f = $urandom_range(0, DEPTH - 1);
      l = f + $urandom_range(0, 200);
      if (l > DEPTH - 1) l = DEPTH - 1;
      do_op($sformatf("fill_rand%0d", k), 1'b0, f, l, 0, DW'($urandom), -1);
    end

    preload(1'b1);
    do_op("scroll1", 1'b1, 0, 0, 1, 8'h2e, 300);
    do_op("scroll0", 1'b1, 0, 0, 0, 8'h11, -1);
    do_op("scroll32", 1'b1, 0, 0, 32, 8'h33, -1);
    preload(1'b0);
    do_op("scroll45", 1'b1, 0, 0, 45, 8'h44, -1);
    for (int k = 0; k < 2; k++) begin
      preload(1'b0);
      do_op($sformatf("scroll_rand%0d", k), 1'b1, 0, 0, $urandom_range(2, 31), DW'($urandom), -1);
    end

    preload(1'b0);
    take_snap();
    for (int a = 0; a < DEPTH; a++) expm[a] = snap[a];
    for (int a = 0; a < 4; a++) expm[a] = 8'h77;
    run_op(1'b0, 0, DEPTH - 1, 0, 8'h77, -1, -1, 5, d_cyc, b_cyc);
    #1;
    check("rst_mid.outputs", {busy, done, ce, w, addr, din}, '0);
    repeat (3) @(negedge clk);
    check("rst_mid.writes", wr_cnt, 4);
    mem_check("rst_mid");
    rst_n = 1'b1;
    exp_addr = 0;
    do_op("after_rst", 1'b0, 100, 130, 0, 8'h66, -1);

`ifdef VRAM_BLIT_ABORT_EN
    take_snap();
    for (int a = 0; a < DEPTH; a++) expm[a] = snap[a];
    for (int a = 0; a < 100; a++) expm[a] = 8'h55;
    run_op(1'b0, 0, DEPTH - 1, 0, 8'h55, -1, 100, -1, d_cyc, b_cyc);
    check("abort.done_cycle", d_cyc, 101);
    check("abort.writes", wr_cnt, 100);
    check("abort.last_write", last_wr, 99);
    @(negedge clk);
    check("abort.idle", {done, busy, ce}, 3'b000);
    mem_check("abort");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vram_blit.md
Name: vram_blit

Overview:
- Parametrised successor to the screen-clear engine.
- Fills an arbitrary linear VRAM range with a constant character, or scrolls the text screen up by N rows and then blanks the vacated rows.
- Sits between the terminal control FSM and the VRAM write port. Owns the port while o_busy=1.
- The VRAM has a synchronous read port with 1-cycle latency.

Parameters:
- ADDR_W, 11, VRAM address width.
- DATA_W, 8, VRAM word width (character code).
- COLS, 64, characters per row; row r, column c maps to address r*COLS+c.
- ROWS, 32, rows on screen; ROWS*COLS must be <= 2**ADDR_W.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  command strobe; sampled only when o_busy=0.
- i_mode  in  1  0=FILL, 1=SCROLL.
- i_first  in  ADDR_W  FILL: first address, inclusive.
- i_last  in  ADDR_W  FILL: last address, inclusive.
- i_nrows  in  $clog2(ROWS+1)  SCROLL: number of rows to scroll.
- i_fill  in  DATA_W  fill character; latched at start.
- o_busy  out  1  operation in progress.
- o_done  out  1  one-cycle pulse on completion.
- o_vram_addr  out  ADDR_W  VRAM address.
- o_vram_ce  out  1  VRAM chip enable.
- o_vram_w  out  1  VRAM write enable.
- o_vram_din  out  DATA_W  VRAM write data.
- i_vram_dout  in  DATA_W  VRAM read data; valid the cycle after a read.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0. A reset mid-operation aborts immediately; no further VRAM access.
- Start: i_start=1 in IDLE latches i_mode, i_first, i_last, i_nrows, i_fill. i_start while busy is ignored. Operands are not re-sampled during an operation.
- States:
  - IDLE: on start, go to FILL or SCR_RD.
  - FILL: one write per cycle, addr = cur; ce=w=1; din=fill. When cur==end, go to DONE; otherwise cur+1.
  - SCR_RD: addr = cur+nrows*COLS; ce=1, w=0. Next state SCR_WR.
  - SCR_WR: addr = cur; ce=w=1; din=i_vram_dout. If cur == (ROWS-nrows)*COLS-1, go to FILL with cur=(ROWS-nrows)*COLS and end=ROWS*COLS-1; otherwise cur+1, back to SCR_RD.
  - DONE: o_busy=0, o_done=1 for one cycle, then IDLE.
- o_busy=1 in FILL, SCR_RD and SCR_WR, starting the cycle after the accepted start.
- FILL latency: N=last-first+1 write cycles, then o_done in cycle N+1 after start.
- FILL boundaries:
  - first>last: no writes; DONE on the cycle after start.
  - last=2**ADDR_W-1 must not wrap cur; the comparison stops it.
- SCROLL boundaries:
  - nrows=0: no accesses; DONE next cycle.
  - nrows>=ROWS: copy phase skipped; whole screen [0, ROWS*COLS-1] filled.
  - Otherwise: 2*(ROWS-nrows)*COLS copy cycles, then nrows*COLS fill cycles, then DONE.
- Address arithmetic is done at ADDR_W+1 bits internally; the comparisons must not overflow.
- When idle: ce=w=0, addr holds its last value, din=0.

Optional Feature:
- Macro: VRAM_BLIT_ABORT_EN.
- Defined: adds input port i_abort (1 bit). i_abort=1 while busy forces DONE on the next cycle. A write already on the port in that cycle completes; no later accesses; o_done still pulses once.
- Undefined: port absent; operations always run to completion.

Test Plan:
- Reset mid-FILL, with i_rst_n low at cycle 5 of a 0..2047 fill -> all outputs 0 immediately; VRAM holds only words 0..3 written; after release the block is IDLE and accepts a new start.
- FILL first=0, last=2047, fill=0x20 -> 2048 consecutive write cycles, all VRAM=0x20, o_done at cycle 2049, i_start during busy ignored.
- FILL first=10, last=9 -> no ce/w asserted, o_done the cycle after start; FILL first=2047, last=2047 -> exactly one write at 2047, no wrap to 0.
- SCROLL nrows=1, VRAM preloaded with word=row index -> rows 0..30 hold 1..31, row 31 all fill value; 3968 copy cycles + 64 fill cycles, o_done at cycle 4033.
- SCROLL nrows=0 -> no accesses, done next cycle; SCROLL nrows=32 -> entire screen = fill, no read cycles.
- With VRAM_BLIT_ABORT_EN defined: i_abort at cycle 100 of a FILL 0..2047 -> last write at address <=99, o_busy low and o_done high one cycle later.
